tff_count_sequencer: RTL and testbench

Run-control sequencer for a T-flip-flop counter datapath. The counter state is held as a bank of T flip-flops updated as `out <= out ^ t_en`. The block computes the toggle vector for the selected count mode and sequences runs with start/stop control, pause/resume and terminal-count detection. It sits between a host controller issuing start/stop and the counter datapath, and reports busy and done status.

---
 rtl/tff_count_sequencer_if.sv | 25 ++
 rtl/tff_count_sequencer.sv | 143 ++++++++++++++
 tb/tb_tff_count_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/tff_count_sequencer_if.sv
// Host <-> sequencer bundle for tff_count_sequencer.
// The host (master) issues run control and run parameters; the sequencer
// (slave) returns the counter state, the live toggle vector and status.
interface tff_count_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] t_en;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, mode, limit,
        input  out, t_en, busy, done
    );

    modport slave (
        input  start, stop, mode, limit,
        output out, t_en, busy, done
    );
endinterface

// File: rtl/tff_count_sequencer.sv
// Run-control sequencer for a T-flip-flop counter bank.
// The counter only ever changes as out <= out ^ t_en; this block builds the
// toggle vector for the latched count mode (binary up, binary down, Gray up)
// and sequences runs through IDLE / RUN / PAUSE / DONE with terminal-count
// detection against a latched limit.
// Optional feature macro: TFF_SEQ_GRAY_EN -- when defined, mode 2'b10 counts
// in Gray code; when undefined the Gray logic is absent and mode 2'b10
// counts binary up (as does the reserved mode 2'b11).
module tff_count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    tff_count_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] limit_reg;
    logic [1:0]       mode_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH-1:0] t_en_comb;
    logic             latch_en;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_down;
    logic [WIDTH-1:0] step_vec;

    // Binary up/down toggle vectors: bit i flips when every lower bit is
    // 1 (up) or 0 (down); bit 0 always flips. Wrap falls out naturally.
    assign t_up[0]   = 1'b1;
    assign t_down[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_bin_step
            assign t_up[gi]   = &out_reg[gi-1:0];
            assign t_down[gi] = &(~out_reg[gi-1:0]);
        end
    endgenerate

`ifdef TFF_SEQ_GRAY_EN
    logic [WIDTH-1:0] gray_bin;
    logic [WIDTH-1:0] gray_bin_inc;
    logic [WIDTH-1:0] gray_next;
    logic [WIDTH-1:0] t_gray;

    // Gray -> binary: each binary bit is the parity of the Gray bits at and
    // above it, written as a per-bit reduction to avoid a chained vector.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gray2bin
            assign gray_bin[gi] = ^out_reg[WIDTH-1:gi];
        end
    endgenerate

    assign gray_bin_inc = gray_bin + {{(WIDTH-1){1'b0}}, 1'b1};
    assign gray_next    = gray_bin_inc ^ (gray_bin_inc >> 1);
    assign t_gray       = out_reg ^ gray_next;
`endif

    // Select the step vector for the latched mode; reserved mode counts up.
    always_comb begin
        step_vec = t_up;
        case (mode_reg)
            2'b01:   step_vec = t_down;
`ifdef TFF_SEQ_GRAY_EN
            2'b10:   step_vec = t_gray;
`endif
            default: step_vec = t_up;
        endcase
    end

    // Next-state and toggle-vector decode. stop outranks start everywhere;
    // the terminal step in RUN outranks stop.
    always_comb begin
        state_next = state_reg;
        t_en_comb  = '0;
        latch_en   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    t_en_comb  = out_reg;  // clears the bank to zero
                    latch_en   = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                t_en_comb = step_vec;
                if ((out_reg ^ step_vec) == limit_reg) begin
                    state_next = ST_DONE;
                end else if (bus.stop) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (bus.stop) begin
                    state_next = ST_IDLE;
                end else if (bus.start) begin
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, T-flip-flop bank, run parameters and registered status flags.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg <= ST_IDLE;
            out_reg   <= '0;
            limit_reg <= '0;
            mode_reg  <= 2'b00;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_reg ^ t_en_comb;
            if (latch_en) begin
                mode_reg  <= bus.mode;
                limit_reg <= bus.limit;
            end
            busy_reg <= (state_next == ST_RUN) || (state_next == ST_PAUSE);
            done_reg <= (state_next == ST_DONE);
        end
    end

    assign bus.out  = out_reg;
    assign bus.t_en = t_en_comb;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Self-checking bench for tff_count_sequencer (WIDTH = 4).
// A phase/count model computed with plain arithmetic predicts out, busy,
// done and the toggle vector (old out XOR new out) every cycle.
module tb_tff_count_sequencer;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_PAUSE = 2;
    localparam int P_DONE  = 3;

    logic Clk;
    logic Rst;

    tff_count_sequencer_if #(.WIDTH(W)) bus ();

    tff_count_sequencer #(.WIDTH(W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_out = 0;
    int m_ph  = P_IDLE;
    int m_mode = 0;
    int m_lim  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next count value for one step in the given mode.
    function automatic int advance(input int o, input int md);
        int b;
        if (md == 1) return (o - 1) & MASK;
`ifdef TFF_SEQ_GRAY_EN
        if (md == 2) begin
            b = o;
            for (int s = 1; s < W; s++) b = b ^ (o >> s);
            b = (b + 1) & MASK;
            return b ^ (b >> 1);
        end
`endif
        return (o + 1) & MASK;
    endfunction

    // One clock cycle: drive inputs, check t_en, clock, check outputs.
    // Entered and left at 1 time unit after a rising edge.
    task automatic cyc(input bit s, input bit p, input int md, input int lm);
        int n_out;
        int n_ph;
        bus.start = s;
        bus.stop  = p;
        bus.mode  = md[1:0];
        bus.limit = lm[W-1:0];
        n_out = m_out;
        n_ph  = m_ph;
        case (m_ph)
            P_IDLE: if (s && !p) begin
                n_out  = 0;
                n_ph   = P_RUN;
                m_mode = md;
                m_lim  = lm & MASK;
            end
            P_RUN: begin
                n_out = advance(m_out, m_mode);
                if (n_out == m_lim) n_ph = P_DONE;
                else if (p)         n_ph = P_PAUSE;
            end
            P_PAUSE: begin
                if (p)      n_ph = P_IDLE;
                else if (s) n_ph = P_RUN;
            end
            default: n_ph = P_IDLE;
        endcase
        #1;
        chk("t_en", 32'(bus.t_en), 32'(m_out ^ n_out));
`ifdef TFF_SEQ_GRAY_EN
        if (m_ph == P_RUN && m_mode == 2)
            chk("gray_onehot", 32'($countones(bus.t_en)), 32'd1);
`endif
        @(posedge Clk);
        m_out = n_out;
        m_ph  = n_ph;
        #1;
        $display("cyc start=%0d stop=%0d mode=%0d lim=%0d -> out=%0d busy=%0d done=%0d",
                 s, p, md, lm, bus.out, bus.busy, bus.done);
        chk("out",  32'(bus.out),  32'(m_out));
        chk("busy", 32'(bus.busy), 32'(m_ph == P_RUN || m_ph == P_PAUSE));
        chk("done", 32'(bus.done), 32'(m_ph == P_DONE));
    endtask

    // Asynchronous reset between edges; effect must be visible without a clock.
    task automatic async_reset();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        #2;
        Rst = 1'b1;
        #1;
        chk("rst_out",  32'(bus.out),  32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        m_out = 0;
        m_ph  = P_IDLE;
        m_mode = 0;
        m_lim  = 0;
        #1;
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        $display("async reset applied");
    endtask

    initial begin
        Rst       = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 2'b00;
        bus.limit = '0;
        #12;
        chk("reset_out",  32'(bus.out),  32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        Rst = 1'b0;
        @(posedge Clk);
        #1;

        // Binary up to 5, done pulse, then IDLE holding 5
        cyc(1, 0, 0, 5);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0);
        chk("up_idle_out", 32'(bus.out), 32'd5);

        // Repeat and reset mid-run
        cyc(1, 0, 0, 5);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        async_reset();

        // Down with wrap to 13
        cyc(1, 0, 1, 13);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        chk("down_idle_out", 32'(bus.out), 32'd13);

        // Gray (or binary without the feature), full 16-step run
        cyc(1, 0, 2, 0);
        for (int i = 0; i < 18; i++) cyc(0, 0, 0, 0);
        chk("gray_idle_out", 32'(bus.out), 32'd0);

        // Pause at 3, hold, resume to 4,5, pause at 5, abort
        cyc(1, 0, 0, 10);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("pause_out", 32'(bus.out), 32'd3);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("abort_out",  32'(bus.out),  32'd5);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        cyc(0, 0, 0, 0);

        // start+stop together in RUN -> PAUSE, then abort
        cyc(1, 0, 0, 9);
        cyc(1, 1, 0, 0);
        chk("startstop_busy", 32'(bus.busy), 32'd1);
        cyc(0, 1, 0, 0);

        // stop on the terminal step (limit 2) -> DONE
        cyc(1, 0, 0, 2);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("term_stop_done", 32'(bus.done), 32'd1);
        cyc(0, 0, 0, 0);

        // start with a new limit during RUN is ignored
        cyc(1, 0, 0, 6);
        for (int i = 0; i < 7; i++) cyc(1, 0, 1, 2);
        chk("ignore_start_out", 32'(bus.out), 32'd6);
        cyc(0, 0, 0, 0);

        // Randomized run-control traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(149, 0) == 0) begin
                async_reset();
            end else begin
                cyc(($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0),
                    int'($urandom_range(3, 0)), int'($urandom_range(MASK, 0)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
